// File: rtl/hbm_core_bridge.sv
// ---------------------------------------------------------------------------
// hbm_core_bridge
//
// Connects a simple valid/ready core interface to an HBM memory controller
// that uses AXI-Stream.
//
// Command path: the core presents {op, address} plus a write payload. Each
// accepted command is stored in a small FIFO as {tuser, data} and streamed
// to the controller on m_axis_wr_*. Reads and writes travel on this one
// stream, and tuser[MSB] carries the op bit.
//
// Read path: the controller returns read beats on s_axis_rd_*. They are
// buffered in a FIFO and handed to the core in order. A credit counter
// limits the number of outstanding reads to the free space in the read
// FIFO, so under a correct protocol the read FIFO never overflows.
//
// Ports
//   ap_clk, ap_rst_n      clock and asynchronous active-low reset
//   o_controller_ready    core command accept
//   i_command_valid       core command valid
//   i_command             {op, 2 reserved bits, address}, op=1 means read
//   i_write_data          write payload
//   o_read_data_valid     read beat available to the core
//   i_read_data_ready     core accepts the read beat
//   o_read_data           read payload (head of the read FIFO)
//   o_rd_credit           number of reads that may still be issued
//   m_axis_wr_*           AXI-Stream master toward the controller
//   s_axis_rd_*           AXI-Stream slave from the controller (tkeep and
//                         tlast are ignored)
// ---------------------------------------------------------------------------

// Synchronous FIFO with registered storage and no bypass path. The pointers
// carry one extra wrap bit. The FIFO is full when the wrap bits differ and
// the index bits match. A push into a full FIFO is dropped, and a pop from
// an empty FIFO is ignored.
module hbm_core_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array is not reset. Its contents are don't-care
    // until a pointer marks an entry valid, and leaving the reset out lets
    // the array map onto plain RAM or flops without a reset tree.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples values from before the edge, regardless of the
    // order in which the blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

module hbm_core_bridge #(
    parameter int C_M_AXIS_WR_TUSER_WIDTH = 23,
    parameter int C_M_AXIS_WR_TDATA_WIDTH = 1024,
    parameter int C_S_AXIS_RD_TDATA_WIDTH = 1024,
    parameter int CMD_FIFO_DEPTH          = 4,
    parameter int RD_FIFO_DEPTH           = 8
) (
    input  logic                                      ap_clk,
    input  logic                                      ap_rst_n,

    // Core command side
    output logic                                      o_controller_ready,
    input  logic                                      i_command_valid,
    input  logic [C_M_AXIS_WR_TUSER_WIDTH+1:0]        i_command,
    input  logic [C_M_AXIS_WR_TDATA_WIDTH-1:0]        i_write_data,

    // Core read-return side
    output logic                                      o_read_data_valid,
    input  logic                                      i_read_data_ready,
    output logic [C_S_AXIS_RD_TDATA_WIDTH-1:0]        o_read_data,
    output logic [$clog2(RD_FIFO_DEPTH+1)-1:0]        o_rd_credit,

    // AXI-Stream master toward the controller
    output logic                                      m_axis_wr_tvalid,
    input  logic                                      m_axis_wr_tready,
    output logic [C_M_AXIS_WR_TDATA_WIDTH-1:0]        m_axis_wr_tdata,
    output logic [C_M_AXIS_WR_TUSER_WIDTH-1:0]        m_axis_wr_tuser,
    output logic [C_M_AXIS_WR_TDATA_WIDTH/8-1:0]      m_axis_wr_tkeep,
    output logic                                      m_axis_wr_tlast,

    // AXI-Stream slave from the controller
    input  logic                                      s_axis_rd_tvalid,
    output logic                                      s_axis_rd_tready,
    input  logic [C_S_AXIS_RD_TDATA_WIDTH-1:0]        s_axis_rd_tdata,
    input  logic [C_S_AXIS_RD_TDATA_WIDTH/8-1:0]      s_axis_rd_tkeep,
    input  logic                                      s_axis_rd_tlast
);

    localparam int TUW  = C_M_AXIS_WR_TUSER_WIDTH;
    localparam int WDW  = C_M_AXIS_WR_TDATA_WIDTH;
    localparam int RDW  = C_S_AXIS_RD_TDATA_WIDTH;
    localparam int CW   = TUW + 2;
    localparam int CNTW = $clog2(RD_FIFO_DEPTH + 1);
    localparam int CEW  = TUW + WDW;

    // ------------------------------------------------------------------
    // Ready gating: this register is cleared by reset and set on the first
    // clock after release. It keeps both ready outputs low while reset is
    // active, even though the FIFOs report "not full" in that state.
    // ------------------------------------------------------------------
    logic run;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) run <= 1'b0;
        else           run <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Command path
    // ------------------------------------------------------------------
    logic           cmd_op;
    logic [TUW-1:0] cmd_tuser;
    logic           cmd_push;
    logic           cmd_pop;
    logic           cmd_full;
    logic           cmd_empty;
    logic [CEW-1:0] cmd_din;
    logic [CEW-1:0] cmd_dout;
    logic [CNTW-1:0] rd_credit;

    assign cmd_op    = i_command[CW-1];
    // The two reserved bits are dropped; tuser = {op, address}.
    assign cmd_tuser = {i_command[CW-1], i_command[CW-4:0]};
    assign cmd_din   = {cmd_tuser, i_write_data};

    // Readiness depends only on registered state plus the op bit of the
    // offered command. A pop in the same cycle does not free a slot early.
    // A write may be accepted even when the read credits are used up.
    assign o_controller_ready = run & !cmd_full & (!cmd_op | (rd_credit != '0));
    assign cmd_push           = i_command_valid & o_controller_ready;

    assign m_axis_wr_tvalid = !cmd_empty;
    assign cmd_pop          = m_axis_wr_tvalid & m_axis_wr_tready;
    assign m_axis_wr_tuser  = cmd_dout[CEW-1:WDW];
    assign m_axis_wr_tdata  = cmd_dout[WDW-1:0];
    assign m_axis_wr_tkeep  = '1;
    assign m_axis_wr_tlast  = 1'b0;

    hbm_core_bridge_fifo #(
        .WIDTH (CEW),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .din   (cmd_din),
        .dout  (cmd_dout),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    // ------------------------------------------------------------------
    // Read-return path
    // ------------------------------------------------------------------
    logic rd_push;
    logic rd_pop;
    logic rd_full;
    logic rd_empty;

    assign s_axis_rd_tready  = run & !rd_full;
    assign rd_push           = s_axis_rd_tvalid & s_axis_rd_tready;
    assign o_read_data_valid = !rd_empty;
    assign rd_pop            = o_read_data_valid & i_read_data_ready;

    hbm_core_bridge_fifo #(
        .WIDTH (RDW),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .push  (rd_push),
        .pop   (rd_pop),
        .din   (s_axis_rd_tdata),
        .dout  (o_read_data),
        .full  (rd_full),
        .empty (rd_empty)
    );

    // ------------------------------------------------------------------
    // Read credits: one credit for each free read-FIFO slot that is not
    // already promised to an outstanding read. An accepted read takes a
    // credit and a beat delivered to the core returns one.
    // ------------------------------------------------------------------
    logic            rd_take;
    logic [CNTW-1:0] credit_next;

    assign rd_take = cmd_push & cmd_op;

    // NOTE: credit_next gets a default value before the conditional updates.
    // Without it, the no-change path would infer a latch.
    always_comb begin
        credit_next = rd_credit;
        if (rd_take && !rd_pop)      credit_next = rd_credit - 1'b1;
        else if (rd_pop && !rd_take) credit_next = rd_credit + 1'b1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rd_credit <= CNTW'(RD_FIFO_DEPTH);
        else           rd_credit <= credit_next;
    end

    assign o_rd_credit = rd_credit;

    // The return sideband and the reserved command bits carry no meaning
    // for this bridge.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, s_axis_rd_tkeep, s_axis_rd_tlast, i_command[CW-2:CW-3]};

endmodule

// File: tb/tb_hbm_core_bridge.sv
// ---------------------------------------------------------------------------
// tb_hbm_core_bridge
//
// Directed self-checking bench for hbm_core_bridge with default parameters
// (TUSER 23, data 1024, command depth 4, read depth 8). Inputs change and
// outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_hbm_core_bridge;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic            o_controller_ready;
    logic            i_command_valid;
    logic [24:0]     i_command;
    logic [1023:0]   i_write_data;
    logic            o_read_data_valid;
    logic            i_read_data_ready;
    logic [1023:0]   o_read_data;
    logic [3:0]      o_rd_credit;
    logic            m_axis_wr_tvalid;
    logic            m_axis_wr_tready;
    logic [1023:0]   m_axis_wr_tdata;
    logic [22:0]     m_axis_wr_tuser;
    logic [127:0]    m_axis_wr_tkeep;
    logic            m_axis_wr_tlast;
    logic            s_axis_rd_tvalid;
    logic            s_axis_rd_tready;
    logic [1023:0]   s_axis_rd_tdata;
    logic [127:0]    s_axis_rd_tkeep;
    logic            s_axis_rd_tlast;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    hbm_core_bridge dut (
        .ap_clk             (ap_clk),
        .ap_rst_n           (ap_rst_n),
        .o_controller_ready (o_controller_ready),
        .i_command_valid    (i_command_valid),
        .i_command          (i_command),
        .i_write_data       (i_write_data),
        .o_read_data_valid  (o_read_data_valid),
        .i_read_data_ready  (i_read_data_ready),
        .o_read_data        (o_read_data),
        .o_rd_credit        (o_rd_credit),
        .m_axis_wr_tvalid   (m_axis_wr_tvalid),
        .m_axis_wr_tready   (m_axis_wr_tready),
        .m_axis_wr_tdata    (m_axis_wr_tdata),
        .m_axis_wr_tuser    (m_axis_wr_tuser),
        .m_axis_wr_tkeep    (m_axis_wr_tkeep),
        .m_axis_wr_tlast    (m_axis_wr_tlast),
        .s_axis_rd_tvalid   (s_axis_rd_tvalid),
        .s_axis_rd_tready   (s_axis_rd_tready),
        .s_axis_rd_tdata    (s_axis_rd_tdata),
        .s_axis_rd_tkeep    (s_axis_rd_tkeep),
        .s_axis_rd_tlast    (s_axis_rd_tlast)
    );

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    // Offer one command for a single cycle and expect it to be accepted.
    task automatic send_cmd(input logic op, input logic [21:0] addr, input logic [1023:0] data);
        i_command_valid = 1'b1;
        i_command       = {op, 2'b00, addr};
        i_write_data    = data;
        #1;
        check("cmd_ready", o_controller_ready, 1'b1);
        tick();
        i_command_valid = 1'b0;
    endtask

    // Return one read beat from the controller; the FIFO must have room.
    task automatic ret_beat(input logic [1023:0] data);
        s_axis_rd_tvalid = 1'b1;
        s_axis_rd_tdata  = data;
        #1;
        check("rd_tready", s_axis_rd_tready, 1'b1);
        tick();
        s_axis_rd_tvalid = 1'b0;
    endtask

    // Pop one read beat at the core side and check its value.
    task automatic pop_beat(input logic [1023:0] exp);
        i_read_data_ready = 1'b1;
        #1;
        check("rd_valid", o_read_data_valid, 1'b1);
        check("rd_data", o_read_data, exp);
        tick();
        i_read_data_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        ap_rst_n          = 1'b0;
        i_command_valid   = 1'b1;       // offered write must be ignored in reset
        i_command         = '0;
        i_write_data      = '0;
        i_read_data_ready = 1'b0;
        m_axis_wr_tready  = 1'b1;
        s_axis_rd_tvalid  = 1'b1;
        s_axis_rd_tdata   = 1024'hDEAD;
        s_axis_rd_tkeep   = '1;
        s_axis_rd_tlast   = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", o_controller_ready, 1'b0);
        check("rst_tvalid", m_axis_wr_tvalid, 1'b0);
        check("rst_rd_valid", o_read_data_valid, 1'b0);
        check("rst_rd_tready", s_axis_rd_tready, 1'b0);
        check("rst_credit", o_rd_credit, 4'd8);
        ap_rst_n = 1'b1;
        #1;
        check("rel_before_clk_ready", o_controller_ready, 1'b0);
        i_command_valid  = 1'b0;
        s_axis_rd_tvalid = 1'b0;
        tick();
        check("rel_cmd_ready", o_controller_ready, 1'b1);
        check("rel_rd_tready", s_axis_rd_tready, 1'b1);
        check("rel_tvalid", m_axis_wr_tvalid, 1'b0);
        check("rel_credit", o_rd_credit, 4'd8);

        // ---------------- write burst ----------------
        check("burst_pre_tvalid", m_axis_wr_tvalid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send_cmd(1'b0, 22'(16 + k), 1024'(32'hD0 + k));
            check("burst_tvalid", m_axis_wr_tvalid, 1'b1);
            check("burst_tdata", m_axis_wr_tdata, 1024'(32'hD0 + k));
            check("burst_tuser", m_axis_wr_tuser, {1'b0, 22'(16 + k)});
            check("burst_tkeep", m_axis_wr_tkeep, {128{1'b1}});
            check("burst_tlast", m_axis_wr_tlast, 1'b0);
        end
        tick();
        check("burst_drained", m_axis_wr_tvalid, 1'b0);

        // ---------------- backpressure ----------------
        m_axis_wr_tready = 1'b0;
        for (int k = 0; k < 4; k++) send_cmd(1'b0, 22'(32 + k), 1024'(32'hE0 + k));
        i_command_valid = 1'b1;
        i_command       = {1'b0, 2'b00, 22'h24};
        i_write_data    = 1024'hE4;
        #1;
        check("bp_full_ready", o_controller_ready, 1'b0);
        tick();
        check("bp_hold_ready", o_controller_ready, 1'b0);
        check("bp_hold_tdata", m_axis_wr_tdata, 1024'hE0);
        m_axis_wr_tready = 1'b1;
        #1;
        check("bp_drain_ready", o_controller_ready, 1'b0);
        tick();
        check("bp_after_pop_ready", o_controller_ready, 1'b1);
        check("bp_head1", m_axis_wr_tdata, 1024'hE1);
        tick();
        i_command_valid = 1'b0;
        check("bp_head2", m_axis_wr_tdata, 1024'hE2);
        tick();
        check("bp_head3", m_axis_wr_tdata, 1024'hE3);
        tick();
        check("bp_head4", m_axis_wr_tdata, 1024'hE4);
        check("bp_head4_tuser", m_axis_wr_tuser, {1'b0, 22'h24});
        tick();
        check("bp_empty", m_axis_wr_tvalid, 1'b0);

        // ---------------- credit exhaustion ----------------
        for (int k = 0; k < 8; k++) send_cmd(1'b1, 22'(64 + k), '0);
        check("cr_zero", o_rd_credit, 4'd0);
        i_command_valid = 1'b1;
        i_command       = {1'b1, 2'b00, 22'h48};
        #1;
        check("cr_read_blocked", o_controller_ready, 1'b0);
        send_cmd(1'b0, 22'h99, 1024'h99);
        check("cr_write_tuser", m_axis_wr_tuser, {1'b0, 22'h99});
        tick();
        ret_beat(1024'h55);
        check("cr_rd_latency", o_read_data_valid, 1'b1);
        check("cr_still_zero", o_rd_credit, 4'd0);
        pop_beat(1024'h55);
        check("cr_one", o_rd_credit, 4'd1);
        send_cmd(1'b1, 22'h48, '0);
        check("cr_read_tuser", m_axis_wr_tuser, {1'b1, 22'h48});
        check("cr_zero_again", o_rd_credit, 4'd0);

        // ---------------- simultaneous take/return ----------------
        ret_beat(1024'h66);
        ret_beat(1024'h77);
        pop_beat(1024'h66);
        check("sim_pre_credit", o_rd_credit, 4'd1);
        i_command_valid   = 1'b1;
        i_command         = {1'b1, 2'b00, 22'h50};
        i_read_data_ready = 1'b1;
        #1;
        check("sim_ready", o_controller_ready, 1'b1);
        check("sim_data", o_read_data, 1024'h77);
        tick();
        i_command_valid   = 1'b0;
        i_read_data_ready = 1'b0;
        check("sim_credit", o_rd_credit, 4'd1);
        check("sim_rd_empty", o_read_data_valid, 1'b0);

        // Return the 7 reads still outstanding.
        for (int k = 0; k < 7; k++) ret_beat(1024'(32'h200 + k));
        for (int k = 0; k < 7; k++) pop_beat(1024'(32'h200 + k));
        check("sim_credit_full", o_rd_credit, 4'd8);

        // ---------------- pointer wrap, 3 full read-FIFO rounds ----------------
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) send_cmd(1'b1, 22'(k), '0);
            check("wrap_credit0", o_rd_credit, 4'd0);
            for (int k = 0; k < 8; k++) ret_beat({992'(r), 32'(32'h300 + k)});
            check("wrap_full_tready", s_axis_rd_tready, 1'b0);
            for (int k = 0; k < 8; k++) pop_beat({992'(r), 32'(32'h300 + k)});
            check("wrap_credit8", o_rd_credit, 4'd8);
        end

        // ---------------- read stall ----------------
        for (int k = 0; k < 3; k++) send_cmd(1'b1, 22'(k), '0);
        ret_beat(1024'hA);
        ret_beat(1024'hB);
        ret_beat(1024'hC);
        check("stall_head", o_read_data, 1024'hA);
        tick();
        tick();
        check("stall_held_valid", o_read_data_valid, 1'b1);
        check("stall_held_data", o_read_data, 1024'hA);
        i_read_data_ready = 1'b1;
        #1;
        check("stall_a", o_read_data, 1024'hA);
        tick();
        check("stall_b", o_read_data, 1024'hB);
        tick();
        check("stall_c", o_read_data, 1024'hC);
        tick();
        i_read_data_ready = 1'b0;
        check("stall_empty", o_read_data_valid, 1'b0);
        check("stall_credit", o_rd_credit, 4'd8);

        // ---------------- reset mid-stream ----------------
        for (int k = 0; k < 3; k++) send_cmd(1'b1, 22'(k), '0);
        tick();
        m_axis_wr_tready = 1'b0;
        for (int k = 0; k < 3; k++) ret_beat(1024'(32'hF0 + k));
        send_cmd(1'b0, 22'h1, 1024'h1);
        send_cmd(1'b0, 22'h2, 1024'h2);
        check("mid_pre_tvalid", m_axis_wr_tvalid, 1'b1);
        check("mid_pre_credit", o_rd_credit, 4'd5);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("mid_tvalid", m_axis_wr_tvalid, 1'b0);
        check("mid_rd_valid", o_read_data_valid, 1'b0);
        check("mid_cmd_ready", o_controller_ready, 1'b0);
        check("mid_rd_tready", s_axis_rd_tready, 1'b0);
        check("mid_credit", o_rd_credit, 4'd8);
        tick();
        ap_rst_n         = 1'b1;
        m_axis_wr_tready = 1'b1;
        tick();
        check("post_cmd_ready", o_controller_ready, 1'b1);
        check("post_tvalid", m_axis_wr_tvalid, 1'b0);
        check("post_rd_valid", o_read_data_valid, 1'b0);
        check("post_credit", o_rd_credit, 4'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
